// File: rtl/depth_hole_fill_fp16.sv
// Row-wise hole filler for the fp16 depth stream: invalid pixels (7FFF)
// take the last valid depth of the row for up to MAX_RUN pixels.
// Ports: clk_i/rst_i; pixel stream in (data/confidence/col/row/valid_i),
// frame geometry (last_col_i/last_row_i), fill_enable_i; registered
// stream out (data/confidence/col/row/valid/filled_o) and per-frame
// statistics (invalid_count_o, filled_count_o, frame_done_o).
module depth_hole_fill_fp16 #(
    parameter int MAX_RUN = 8,
    parameter int CNT_W   = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [15:0]      data_i,
    input  logic [15:0]      confidence_i,
    input  logic [15:0]      col_i,
    input  logic [15:0]      row_i,
    input  logic             valid_i,
    input  logic [15:0]      last_col_i,
    input  logic [15:0]      last_row_i,
    input  logic             fill_enable_i,
    output logic [15:0]      data_o,
    output logic [15:0]      confidence_o,
    output logic [15:0]      col_o,
    output logic [15:0]      row_o,
    output logic             valid_o,
    output logic             filled_o,
    output logic [CNT_W-1:0] invalid_count_o,
    output logic [CNT_W-1:0] filled_count_o,
    output logic             frame_done_o
);
    localparam logic [15:0]      INV_MARK = 16'h7FFF;
    localparam logic [7:0]       RUN_MAX  = 8'(MAX_RUN);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    logic             hold_valid_q, hold_valid_d;
    logic [15:0]      hold_data_q, hold_data_d;
    logic [7:0]       run_q, run_d;
    logic [CNT_W-1:0] inv_acc_q, fill_acc_q;
    logic [CNT_W-1:0] inv_sum, fill_sum;

    logic             row_start, ref_valid, is_inv, do_fill, frame_end;
    logic [7:0]       run_cur;

    always_comb begin
        // A new row never inherits the previous row's reference.
        row_start = (col_i == 16'd0);
        ref_valid = hold_valid_q & ~row_start;
        run_cur   = row_start ? 8'd0 : run_q;
        is_inv    = (data_i == INV_MARK);
        do_fill   = is_inv & fill_enable_i & ref_valid & (run_cur < RUN_MAX);
        frame_end = valid_i & (col_i == last_col_i) & (row_i == last_row_i);

        inv_sum  = (is_inv && inv_acc_q != CNT_SAT)
                   ? inv_acc_q + CNT_W'(1) : inv_acc_q;
        fill_sum = (do_fill && fill_acc_q != CNT_SAT)
                   ? fill_acc_q + CNT_W'(1) : fill_acc_q;

        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        run_d        = run_q;
        if (valid_i) begin
            if (!is_inv) begin
                hold_valid_d = 1'b1;
                hold_data_d  = data_i;
                run_d        = 8'd0;
            end else begin
                hold_valid_d = ref_valid;
                run_d        = do_fill ? run_cur + 8'd1 : run_cur;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_valid_q    <= 1'b0;
            hold_data_q     <= 16'h0000;
            run_q           <= 8'd0;
            inv_acc_q       <= '0;
            fill_acc_q      <= '0;
            data_o          <= 16'h0000;
            confidence_o    <= 16'h0000;
            col_o           <= 16'h0000;
            row_o           <= 16'h0000;
            valid_o         <= 1'b0;
            filled_o        <= 1'b0;
            invalid_count_o <= '0;
            filled_count_o  <= '0;
            frame_done_o    <= 1'b0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            run_q        <= run_d;
            data_o       <= (valid_i && do_fill) ? hold_data_q : data_i;
            confidence_o <= confidence_i;
            col_o        <= col_i;
            row_o        <= row_i;
            valid_o      <= valid_i;
            filled_o     <= valid_i & do_fill;
            frame_done_o <= frame_end;
            if (frame_end) begin
                invalid_count_o <= inv_sum;
                filled_count_o  <= fill_sum;
                inv_acc_q       <= '0;
                fill_acc_q      <= '0;
            end else if (valid_i) begin
                inv_acc_q  <= inv_sum;
                fill_acc_q <= fill_sum;
            end
        end
    end
endmodule

// File: doc/depth_hole_fill_fp16.md
# depth_hole_fill_fp16

Row-wise hole filler for the fp16 depth stream in the dfdd pipeline. Sits directly downstream of the radial confidence/depth threshold stage and consumes its stream. Pixels that stage marked invalid (16'h7FFF) are replaced with the most recent valid depth in the same row, for up to MAX_RUN consecutive pixels. Per-frame invalid and filled counts are reported at each frame end.

## Interface
- MAX_RUN, 8: maximum consecutive invalid pixels filled from one held value (1..255).
- CNT_W, 20: width of the per-frame statistics counters.

- clk_i  in  1  clock; all state in this single domain.
- rst_i  in  1  reset, asynchronous, active-high.
- data_i  in  16  fp16 depth; 16'h7FFF = invalid marker.
- confidence_i  in  16  fp16 confidence, passed through.
- col_i  in  16  pixel column.
- row_i  in  16  pixel row.
- valid_i  in  1  input pixel qualifier; no backpressure.
- last_col_i  in  16  column index of the final pixel in a row.
- last_row_i  in  16  row index of the final row in a frame.
- fill_enable_i  in  1  1 = fill holes; 0 = pass invalids through.
- data_o  out  16  depth, filled or passed through.
- confidence_o  out  16  registered confidence_i.
- col_o  out  16  registered col_i.
- row_o  out  16  registered row_i.
- valid_o  out  1  registered valid_i.
- filled_o  out  1  1 = this output pixel was substituted.
- invalid_count_o  out  CNT_W  invalid input pixels in the last completed frame.
- filled_count_o  out  CNT_W  filled pixels in the last completed frame.
- frame_done_o  out  1  one-cycle pulse when the count outputs update.

## Operation
- Invalid means data_i == 16'h7FFF exactly. Every other value is valid, including other NaN encodings.
- Per-row fill state has three parts: hold_valid, hold_data[15:0] and run[7:0]. Two logical states:
  - NO_REF: hold_valid = 0.
  - HOLD: hold_valid = 1.
- Each cycle with valid_i = 1, evaluate in this order:
  - Row start (col_i == 0): treat the state as NO_REF with run = 0 for this pixel, whatever the previous row left behind.
  - Valid pixel: data_o = data_i and filled_o = 0. Load hold_data with data_i, set hold_valid = 1, clear run to 0. The hold is updated even when fill_enable_i = 0.
  - Invalid pixel, with fill_enable_i = 1, state HOLD and run < MAX_RUN: data_o = hold_data, filled_o = 1, run increments.
  - Any other invalid pixel: data_o = 16'h7FFF, filled_o = 0, state unchanged. Run saturates at MAX_RUN, so a long hole stays invalid from pixel MAX_RUN+1 until the next valid pixel.
- Cycles with valid_i = 0:
  - Fill state and accumulators are unchanged.
  - Data and coordinate outputs still register their inputs.
  - valid_o = 0 and filled_o = 0.
- Statistics:
  - Accumulator inv_acc increments on each valid invalid input pixel.
  - Accumulator fill_acc increments on each filled pixel.
  - Both saturate at 2^CNT_W − 1.
- Frame end is a valid pixel with col_i == last_col_i and row_i == last_row_i. On that pixel:
  - invalid_count_o and filled_count_o load the totals, including that pixel's contribution.
  - frame_done_o = 1 for exactly one cycle.
  - Both accumulators restart from 0 for the next pixel.
- Reported counts hold their value until the next frame end.

## Timing
- Latency is 1 cycle on all streamed outputs, in lockstep: data, confidence, col, row, valid and filled.
- frame_done_o and the new counts appear in the same cycle as the frame-end pixel on valid_o.
- Throughput is one pixel per cycle. Back-to-back invalid pixels need no bubble.
- Reset: rst_i asserted forces all outputs to 0 immediately, without waiting for a clock edge.
  - This includes data_o = 16'h0000, valid_o = 0, frame_done_o = 0 and both count outputs = 0.
  - It also clears hold_valid, run and both accumulators.
- After rst_i deasserts, the first pixel is processed in NO_REF even if col_i != 0.
- If frame end and row start coincide (last_col_i == 0), the row-start rule applies first, then the frame-end rule.

## Test plan
- MAX_RUN = 2, row 0 with col0..3 = 3C00, 7FFF, 7FFF, 7FFF -> data_o = 3C00, 3C00, 3C00, 7FFF; filled_o = 0, 1, 1, 0.
- Row 0 ends with 4000 valid; row 1 col0 = 7FFF, col1 = 7FFF -> both outputs 7FFF, filled_o = 0 (no carry-over across rows).
- last_col_i = 3, last_row_i = 1, 8 pixels with 3 invalid of which 2 are fillable -> frame_done_o pulses once, 1 cycle after the final input, with invalid_count_o = 3 and filled_count_o = 2. The next frame's counts start from 0.
- fill_enable_i = 0, same stream as test 1 -> all 7FFF passed through, filled_count_o = 0, invalid_count_o = 3. Re-enabling mid-row fills from the last valid pixel.
- valid_i gaps of 3 idle cycles inside a hole -> fill sequence and run count identical to the gap-free case; valid_o = 0 and filled_o = 0 during the gaps.
- Assert rst_i asynchronously mid-row while in HOLD -> outputs go 0 before the next edge. After release, the first invalid pixel outputs 7FFF unfilled and the counts read 0.
